// File: rtl/alu_issue_arbiter_if.sv
// Bundle of requester, ALU and response signals shared by the ALU issue arbiter.
// The arbiter connects through the slave modport; the requesters and ALU side use master.
interface alu_issue_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_func;
    logic        req0_ctrl;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_func;
    logic        req1_ctrl;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_func;
    logic        alu_ctrl;
    logic [31:0] alu_result;

    logic [31:0] rsp_data;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_func, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_func, req1_ctrl,
        output req1_ready,
        output alu_a, alu_b, alu_func, alu_ctrl,
        input  alu_result,
        output rsp_data, rsp0_valid, rsp1_valid,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_func, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_func, req1_ctrl,
        input  req1_ready,
        input  alu_a, alu_b, alu_func, alu_ctrl,
        output alu_result,
        input  rsp_data, rsp0_valid, rsp1_valid,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one registered (single-cycle latency) ALU between the execute stage (req0)
// and the branch/AGU unit (req1); one operation in flight, result returned by handshake.
module alu_issue_arbiter #(
    parameter bit RR_ENABLE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [2:0]         alu_func_q, alu_func_d;
    logic               alu_ctrl_q, alu_ctrl_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               any_valid;
    logic               sel1;

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_func_d     = alu_func_q;
        alu_ctrl_d     = alu_ctrl_q;
        rsp_data_d     = rsp_data_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;

        any_valid = bus.req0_valid | bus.req1_valid;
        // Round-robin hands a contested slot to whoever did not win last time.
        if (RR_ENABLE && bus.req0_valid && bus.req1_valid) begin
            sel1 = ~last_grant_q;
        end else begin
            sel1 = bus.req1_valid & ~bus.req0_valid;
        end

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    bus.req0_ready = ~sel1;
                    bus.req1_ready = sel1;
                    alu_a_d        = sel1 ? bus.req1_a    : bus.req0_a;
                    alu_b_d        = sel1 ? bus.req1_b    : bus.req0_b;
                    alu_func_d     = sel1 ? bus.req1_func : bus.req0_func;
                    alu_ctrl_d     = sel1 ? bus.req1_ctrl : bus.req0_ctrl;
                    owner_d        = sel1;
                    last_grant_d   = sel1;
                    if (sel1) begin
                        if (!(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        if (!(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_data_d = bus.alu_result;
                state_d    = RESP;
            end
            RESP: begin
                bus.rsp0_valid = ~owner_q;
                bus.rsp1_valid = owner_q;
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= '0;
            alu_ctrl_q   <= 1'b0;
            rsp_data_q   <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_data_q   <= rsp_data_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_func = alu_func_q;
    assign bus.alu_ctrl = alu_ctrl_q;
    assign bus.rsp_data = rsp_data_q;
    assign busy         = (state_q != IDLE);
    assign grant_cnt0   = cnt0_q;
    assign grant_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: a round-robin instance checked through a response
// scoreboard, plus a fixed-priority instance with a 2-bit counter for saturation.
module tb_alu_issue_arbiter;

    logic clk;
    logic rst_n;

    alu_issue_arbiter_if ifa();
    alu_issue_arbiter_if ifb();

    logic        busy_a, busy_b;
    logic [15:0] cnt0_a, cnt1_a;
    logic [1:0]  cnt0_b, cnt1_b;

    alu_issue_arbiter #(.RR_ENABLE(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .busy(busy_a), .grant_cnt0(cnt0_a), .grant_cnt1(cnt1_a)
    );

    alu_issue_arbiter #(.RR_ENABLE(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
        .busy(busy_b), .grant_cnt0(cnt0_b), .grant_cnt1(cnt1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: func 000 = ADD (ctrl=1 passes A through, LUI), 010 SLT, 011 SLTU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic c);
        case (f)
            3'b000:  return c ? a : a + b;
            3'b010:  return {31'b0, ($signed(a) < $signed(b))};
            3'b011:  return {31'b0, (a < b)};
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk) begin
        ifa.alu_result <= alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_func, ifa.alu_ctrl);
        ifb.alu_result <= alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_func, ifb.alu_ctrl);
    end

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   nb_rsp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic who, input logic [31:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor for instance A: compare on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((ifa.rsp0_valid && ifa.rsp0_ready) || (ifa.rsp1_valid && ifa.rsp1_ready))) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data 0x%08h owner {%b,%b} expected none",
                         ifa.rsp_data, ifa.rsp1_valid, ifa.rsp0_valid);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {30'b0, ifa.rsp1_valid, ifa.rsp0_valid}, e.who ? 32'd2 : 32'd1);
                chk("rsp_data", ifa.rsp_data, e.data);
            end
        end
    end

    // Monitor for fixed-priority instance B: req1 must never be served.
    always @(negedge clk) begin
        if (rst_n && ifb.rsp1_valid) chk("b_rsp1_never", 32'(ifb.rsp1_valid), 32'd0);
        if (rst_n && ifb.rsp0_valid && ifb.rsp0_ready) begin
            nb_rsp++;
            chk("b_rsp_data", ifb.rsp_data, 32'd3);
        end
    end

    task automatic drive0(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic c);
        int n = 0;
        ifa.req0_a = a; ifa.req0_b = b; ifa.req0_func = f; ifa.req0_ctrl = c;
        ifa.req0_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!ifa.req0_ready && n < 40);
        if (!ifa.req0_ready) chk("req0_accept_timeout", 32'(ifa.req0_ready), 32'd1);
        @(posedge clk); #1;
        ifa.req0_valid = 1'b0;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic c);
        int n = 0;
        ifa.req1_a = a; ifa.req1_b = b; ifa.req1_func = f; ifa.req1_ctrl = c;
        ifa.req1_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!ifa.req1_ready && n < 40);
        if (!ifa.req1_ready) chk("req1_accept_timeout", 32'(ifa.req1_ready), 32'd1);
        @(posedge clk); #1;
        ifa.req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy_a || exp_q.size() != 0) && n < 60);
        if (busy_a || exp_q.size() != 0) chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},     32'(busy_a), 32'd0);
        chk({tag, "_alu_a"},    ifa.alu_a, 32'd0);
        chk({tag, "_alu_b"},    ifa.alu_b, 32'd0);
        chk({tag, "_alu_fc"},   {28'b0, ifa.alu_func, ifa.alu_ctrl}, 32'd0);
        chk({tag, "_rsp_data"}, ifa.rsp_data, 32'd0);
        chk({tag, "_rsp_vld"},  {30'b0, ifa.rsp1_valid, ifa.rsp0_valid}, 32'd0);
        chk({tag, "_cnt0"},     32'(cnt0_a), 32'd0);
        chk({tag, "_cnt1"},     32'(cnt1_a), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        ifa.req0_valid = 0; ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_func = 0; ifa.req0_ctrl = 0;
        ifa.req1_valid = 0; ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_func = 0; ifa.req1_ctrl = 0;
        ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
        ifb.req0_valid = 0; ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_func = 0; ifb.req0_ctrl = 0;
        ifb.req1_valid = 0; ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_func = 0; ifb.req1_ctrl = 0;
        ifb.rsp0_ready = 1; ifb.rsp1_ready = 1;

        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 5+7 from req0
        push(1'b0, 32'd12);
        drive0(32'd5, 32'd7, 3'b000, 1'b0);
        wait_idle("add_drain");
        chk("add_cnt0", 32'(cnt0_a), 32'd1);
        chk("add_cnt1", 32'(cnt1_a), 32'd0);

        // Reset during EXEC: operation discarded, no response may follow
        @(posedge clk); #1;
        drive0(32'd9, 32'd9, 3'b000, 1'b0);
        chk("exec_busy", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_exec");
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1;

        // Round-robin: req0 SLT(-1,1)=1 first, then req1 SLTU(-1,1)=0, three pairs
        for (int p = 0; p < 3; p++) begin
            push(1'b0, 32'd1);
            push(1'b1, 32'd0);
            fork
                drive0(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0);
                drive1(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0);
            join
        end
        wait_idle("rr_drain");
        chk("rr_cnt0", 32'(cnt0_a), 32'd3);
        chk("rr_cnt1", 32'(cnt1_a), 32'd3);

        // Backpressure on req1 LUI while req0 waits
        @(posedge clk); #1;
        ifa.rsp1_ready = 1'b0;
        push(1'b1, 32'h1234_5000);
        push(1'b0, 32'd123);
        drive1(32'h1234_5000, 32'd0, 3'b000, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!ifa.rsp1_valid && n < 10);
        chk("bp_rsp1_valid_seen", 32'(ifa.rsp1_valid), 32'd1);
        ifa.req0_a = 32'd100; ifa.req0_b = 32'd23; ifa.req0_func = 3'b000; ifa.req0_ctrl = 1'b0;
        ifa.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", 32'(ifa.rsp1_valid), 32'd1);
            chk("bp_rsp0_valid", 32'(ifa.rsp0_valid), 32'd0);
            chk("bp_rsp_data",   ifa.rsp_data, 32'h1234_5000);
            chk("bp_req_ready",  {30'b0, ifa.req1_ready, ifa.req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        ifa.rsp1_ready = 1'b1;
        drive0(32'd100, 32'd23, 3'b000, 1'b0);
        wait_idle("bp_drain");
        chk("bp_cnt0", 32'(cnt0_a), 32'd4);
        chk("bp_cnt1", 32'(cnt1_a), 32'd4);

        // Fixed priority with both valid continuously; 2-bit counter saturates
        ifb.req0_a = 32'd1;  ifb.req0_b = 32'd2;  ifb.req0_func = 3'b000; ifb.req0_ctrl = 1'b0;
        ifb.req1_a = 32'd10; ifb.req1_b = 32'd20; ifb.req1_func = 3'b000; ifb.req1_ctrl = 1'b0;
        ifb.req0_valid = 1'b1;
        ifb.req1_valid = 1'b1;
        repeat (30) @(negedge clk);
        ifb.req0_valid = 1'b0;
        ifb.req1_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_cnt0_sat", 32'(cnt0_b), 32'd3);
        chk("b_cnt1_zero", 32'(cnt1_b), 32'd0);
        chk("b_enough_ops", 32'(nb_rsp >= 5), 32'd1);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
